// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with immediate decode, operand select, hazard
// detection and (optionally) EX-stage operand forwarding.
//
// Build option: define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding
// with load-use bubble insertion. Left undefined, no forwarding is done and
// any RAW dependency on an in-flight writer stalls the decode stage.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   if_valid_i/if_instr_i/if_pc_i  incoming instruction from fetch
//   id_ready_o                     incoming instruction accepted this edge
//   rs1_addr_o/rs2_addr_o          register-file read addresses
//   rs1_data_i/rs2_data_i          register-file read data
//   flush_i, ex_stall_i            taken-branch flush, downstream hold
//   exmem_*/memwb_*                later-stage writer info for hazards/forwarding
//   ex_valid_o .. store_data_o     ALU-facing entry and operands
module id_ex_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid_i,
  input  logic [31:0] if_instr_i,
  input  logic [31:0] if_pc_i,
  output logic        id_ready_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  input  logic        ex_stall_i,
  input  logic [4:0]  exmem_rd_i,
  input  logic        exmem_regwrite_i,
  input  logic        exmem_memread_i,
  input  logic [31:0] exmem_result_i,
  input  logic [4:0]  memwb_rd_i,
  input  logic        memwb_regwrite_i,
  input  logic [31:0] memwb_result_i,
  output logic        ex_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [1:0]  sel_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [31:0] store_data_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // x0 is hardwired zero, so it never creates a dependency
  function automatic logic f_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [1:0]  r_sel;
  logic [31:0] r_rs1_val;
  logic [31:0] r_rs2_val;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic [31:0] r_imm;
  logic [4:0]  r_rd;
  logic        r_load;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [1:0]  w_sel;
  logic [31:0] w_imm;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_has_rd;
  logic        w_is_load;
  logic [4:0]  w_rs1_chk;
  logic [4:0]  w_rs2_chk;
  logic        w_hazard;
  logic        w_bubble;
  logic        w_capture;
  logic [31:0] w_rs1_fwd;
  logic [31:0] w_rs2_fwd;

  assign w_opcode   = if_instr_i[6:0];
  assign w_funct3   = if_instr_i[14:12];
  assign w_rs1      = if_instr_i[19:15];
  assign w_rs2      = if_instr_i[24:20];
  assign rs1_addr_o = w_rs1;
  assign rs2_addr_o = w_rs2;

  // Decode: operand select, immediate and which register fields are live
  always_comb begin
    w_sel     = 2'b00;
    w_imm     = 32'd0;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b1;
    w_has_rd  = 1'b0;
    w_is_load = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_has_rd = 1'b1;
      end
      OP_IMM: begin
        w_sel     = 2'b01;
        w_use_rs2 = 1'b0;
        w_has_rd  = 1'b1;
        // shift amounts live in [24:20] and are unsigned
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
          w_imm = {27'd0, if_instr_i[24:20]};
        else
          w_imm = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
      end
      OP_LOAD, OP_JALR: begin
        w_sel     = 2'b01;
        w_use_rs2 = 1'b0;
        w_has_rd  = 1'b1;
        w_is_load = (w_opcode == OP_LOAD);
        w_imm     = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
      end
      OP_STORE: begin
        w_sel = 2'b01;
        w_imm = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
      end
      OP_BRANCH: begin
        w_sel = 2'b10;
        w_imm = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                 if_instr_i[30:25], if_instr_i[11:8], 1'b0};
      end
      OP_JAL: begin
        w_sel     = 2'b10;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_has_rd  = 1'b1;
        w_imm     = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                     if_instr_i[20], if_instr_i[30:21], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_sel     = 2'b11;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_has_rd  = 1'b1;
        w_imm     = {12'd0, if_instr_i[31:12]};
      end
      default: begin
        // unknown opcodes read both registers like R-type, write nothing
      end
    endcase
  end

  // unused source fields are masked to x0 so they never match
  assign w_rs1_chk = w_use_rs1 ? w_rs1 : 5'd0;
  assign w_rs2_chk = w_use_rs2 ? w_rs2 : 5'd0;

`ifdef ID_EX_FORWARD_EN
  // Only a load directly ahead, or a load sitting in EX/MEM, cannot be forwarded
  assign w_hazard = if_valid_i & (
      (r_valid & r_load & (f_match(w_rs1_chk, r_rd) | f_match(w_rs2_chk, r_rd))) |
      (exmem_memread_i & (f_match(w_rs1_chk, exmem_rd_i) | f_match(w_rs2_chk, exmem_rd_i))));

  // EX/MEM has priority as the younger result; load data is never taken from EX/MEM
  always_comb begin
    w_rs1_fwd = r_rs1_val;
    w_rs2_fwd = r_rs2_val;
    if (exmem_regwrite_i && !exmem_memread_i && f_match(r_rs1_addr, exmem_rd_i))
      w_rs1_fwd = exmem_result_i;
    else if (memwb_regwrite_i && f_match(r_rs1_addr, memwb_rd_i))
      w_rs1_fwd = memwb_result_i;
    if (exmem_regwrite_i && !exmem_memread_i && f_match(r_rs2_addr, exmem_rd_i))
      w_rs2_fwd = exmem_result_i;
    else if (memwb_regwrite_i && f_match(r_rs2_addr, memwb_rd_i))
      w_rs2_fwd = memwb_result_i;
  end
`else
  logic [4:0] w_ex_rd;
  logic [4:0] w_exmem_rd;
  logic [4:0] w_memwb_rd;
  logic       w_unused;

  // Without forwarding, wait until every in-flight writer of a source has retired
  assign w_ex_rd    = r_valid ? r_rd : 5'd0;
  assign w_exmem_rd = (exmem_regwrite_i | exmem_memread_i) ? exmem_rd_i : 5'd0;
  assign w_memwb_rd = memwb_regwrite_i ? memwb_rd_i : 5'd0;
  assign w_hazard = if_valid_i & (
      f_match(w_rs1_chk, w_ex_rd)    | f_match(w_rs2_chk, w_ex_rd)    |
      f_match(w_rs1_chk, w_exmem_rd) | f_match(w_rs2_chk, w_exmem_rd) |
      f_match(w_rs1_chk, w_memwb_rd) | f_match(w_rs2_chk, w_memwb_rd));

  assign w_rs1_fwd = r_rs1_val;
  assign w_rs2_fwd = r_rs2_val;
  assign w_unused  = ^{exmem_result_i, memwb_result_i, r_load, r_rs1_addr, r_rs2_addr};
`endif

  assign id_ready_o = flush_i | (~ex_stall_i & ~w_hazard);
  assign w_bubble   = reset | flush_i | (~ex_stall_i & (w_hazard | ~if_valid_i));
  assign w_capture  = ~reset & ~flush_i & ~ex_stall_i & ~w_hazard & if_valid_i;

  // Pipeline register: bubble, capture, or hold when stalled
  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc       <= 32'd0;
      r_sel      <= 2'b01;
      r_rs1_val  <= 32'd0;
      r_rs2_val  <= 32'd0;
      r_rs1_addr <= 5'd0;
      r_rs2_addr <= 5'd0;
      r_imm      <= 32'd0;
      r_rd       <= 5'd0;
      r_load     <= 1'b0;
    end else if (w_capture) begin
      r_valid    <= 1'b1;
      r_instr    <= if_instr_i;
      r_pc       <= if_pc_i;
      r_sel      <= w_sel;
      r_rs1_val  <= w_use_rs1 ? rs1_data_i : 32'd0;
      r_rs2_val  <= w_use_rs2 ? rs2_data_i : 32'd0;
      r_rs1_addr <= w_rs1_chk;
      r_rs2_addr <= w_rs2_chk;
      r_imm      <= w_imm;
      r_rd       <= w_has_rd ? if_instr_i[11:7] : 5'd0;
      r_load     <= w_is_load;
    end
  end

  assign ex_valid_o   = r_valid;
  assign instr_o      = r_instr;
  assign pc_o         = r_pc;
  assign sel_o        = r_sel;
  assign store_data_o = w_rs2_fwd;

  // Operand mux: 00 rs1/rs2, 01 rs1/imm, 10 pc/imm, 11 zero/imm
  always_comb begin
    op1_o = w_rs1_fwd;
    op2_o = r_imm;
    case (r_sel)
      2'b00:   op2_o = w_rs2_fwd;
      2'b10:   op1_o = r_pc;
      2'b11:   op1_o = 32'd0;
      default: op1_o = w_rs1_fwd;
    endcase
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode/operand vector table plus
// stall, flush, reset and hazard sequences for the active build.
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        if_valid_i;
  logic [31:0] if_instr_i;
  logic [31:0] if_pc_i;
  logic        id_ready_o;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        flush_i;
  logic        ex_stall_i;
  logic [4:0]  exmem_rd_i;
  logic        exmem_regwrite_i;
  logic        exmem_memread_i;
  logic [31:0] exmem_result_i;
  logic [4:0]  memwb_rd_i;
  logic        memwb_regwrite_i;
  logic [31:0] memwb_result_i;
  logic        ex_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [1:0]  sel_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [31:0] store_data_o;

  id_ex_stage #(.NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .reset(reset),
    .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .id_ready_o(id_ready_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .flush_i(flush_i), .ex_stall_i(ex_stall_i),
    .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i),
    .exmem_memread_i(exmem_memread_i), .exmem_result_i(exmem_result_i),
    .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i),
    .memwb_result_i(memwb_result_i),
    .ex_valid_o(ex_valid_o), .instr_o(instr_o), .pc_o(pc_o), .sel_o(sel_o),
    .op1_o(op1_o), .op2_o(op2_o), .store_data_o(store_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [1:0]  sel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sd;
  } vec_t;

  localparam int unsigned NVEC = 12;
  vec_t vecs [NVEC];

  int n_tests;
  int n_fail;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2);
    if_valid_i = v;
    if_instr_i = ins;
    if_pc_i    = pc;
    rs1_data_i = d1;
    rs2_data_i = d2;
  endtask

  task automatic clear_wb();
    exmem_rd_i = 5'd0; exmem_regwrite_i = 1'b0; exmem_memread_i = 1'b0; exmem_result_i = 32'd0;
    memwb_rd_i = 5'd0; memwb_regwrite_i = 1'b0; memwb_result_i = 32'd0;
  endtask

  task automatic check_bubble(input string nm);
    check({nm, ".valid"}, 32'(ex_valid_o), 32'd0);
    check({nm, ".instr"}, instr_o, 32'h0000_0013);
    check({nm, ".sel"},   32'(sel_o), 32'd1);
    check({nm, ".op1"},   op1_o, 32'd0);
    check({nm, ".op2"},   op2_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //                instr         pc           rs1d          rs2d          sel    op1           op2           store
    vecs[0]  = '{32'h00500093, 32'h100, 32'h0,        32'h0,        2'b01, 32'h0,        32'h5,        32'h0};        // addi x1,x0,5
    vecs[1]  = '{32'h12345137, 32'h104, 32'h5555,     32'h6666,     2'b11, 32'h0,        32'h00012345, 32'h0};        // lui x2
    vecs[2]  = '{32'hFE208CE3, 32'h200, 32'h1234,     32'hAAAA5555, 2'b10, 32'h200,      32'hFFFFFFF8, 32'hAAAA5555}; // beq -8
    vecs[3]  = '{32'hFE322E23, 32'h208, 32'h1000,     32'hDEADBEEF, 2'b01, 32'h1000,     32'hFFFFFFFC, 32'hDEADBEEF}; // sw -4
    vecs[4]  = '{32'h002081B3, 32'h20C, 32'h11,       32'h22,       2'b00, 32'h11,       32'h22,       32'h22};       // add
    vecs[5]  = '{32'h01F31293, 32'h210, 32'h80000001, 32'h99,       2'b01, 32'h80000001, 32'h1F,       32'h0};        // slli 31
    vecs[6]  = '{32'h40335293, 32'h214, 32'hF0,       32'h99,       2'b01, 32'hF0,       32'h3,        32'h0};        // srai 3
    vecs[7]  = '{32'hFFDFF0EF, 32'h300, 32'h77,       32'h88,       2'b10, 32'h300,      32'hFFFFFFFC, 32'h0};        // jal -4
    vecs[8]  = '{32'hFFFFF397, 32'h304, 32'h1,        32'h2,        2'b11, 32'h0,        32'h000FFFFF, 32'h0};        // auipc
    vecs[9]  = '{32'h7FF100E7, 32'h308, 32'h4000,     32'h5,        2'b01, 32'h4000,     32'h7FF,      32'h0};        // jalr 2047
    vecs[10] = '{32'h8000A283, 32'h30C, 32'h2000,     32'h5,        2'b01, 32'h2000,     32'hFFFFF800, 32'h0};        // lw -2048
    vecs[11] = '{32'h0020807F, 32'h310, 32'hA,        32'hB,        2'b00, 32'hA,        32'hB,        32'hB};        // unknown

    reset = 1'b1; flush_i = 1'b0; ex_stall_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    clear_wb();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_bubble("reset");
    check("reset.pc", pc_o, 32'h0);
    check("reset.store", store_data_o, 32'h0);
    check("reset.ready", 32'(id_ready_o), 32'd1);

    // Table: issue each vector, then one idle cycle so no vector depends on another
    for (int i = 0; i < int'(NVEC); i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].rs1d, vecs[i].rs2d);
      #1;
      check($sformatf("v%0d.ready", i), 32'(id_ready_o), 32'd1);
      check($sformatf("v%0d.rs1a", i), 32'(rs1_addr_o), 32'(vecs[i].instr[19:15]));
      check($sformatf("v%0d.rs2a", i), 32'(rs2_addr_o), 32'(vecs[i].instr[24:20]));
      @(negedge clk);
      check($sformatf("v%0d.valid", i), 32'(ex_valid_o), 32'd1);
      check($sformatf("v%0d.instr", i), instr_o, vecs[i].instr);
      check($sformatf("v%0d.pc", i), pc_o, vecs[i].pc);
      check($sformatf("v%0d.sel", i), 32'(sel_o), 32'(vecs[i].sel));
      check($sformatf("v%0d.op1", i), op1_o, vecs[i].op1);
      check($sformatf("v%0d.op2", i), op2_o, vecs[i].op2);
      check($sformatf("v%0d.store", i), store_data_o, vecs[i].sd);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
    end
    check_bubble("idle");

    // Stall holds the entry and refuses new input
    drive(1'b1, 32'h002081B3, 32'h400, 32'h3, 32'h4);
    @(negedge clk);
    check("stall.pre_pc", pc_o, 32'h400);
    ex_stall_i = 1'b1;
    drive(1'b1, 32'h12345137, 32'h404, 32'h0, 32'h0);
    #1 check("stall.ready", 32'(id_ready_o), 32'd0);
    @(negedge clk);
    check("stall.hold_pc", pc_o, 32'h400);
    check("stall.hold_op1", op1_o, 32'h3);
    check("stall.hold_valid", 32'(ex_valid_o), 32'd1);
    ex_stall_i = 1'b0;
    #1 check("stall.release_ready", 32'(id_ready_o), 32'd1);
    @(negedge clk);
    check("stall.next_pc", pc_o, 32'h404);
    check("stall.next_sel", 32'(sel_o), 32'd3);

    // Flush wins over stall
    ex_stall_i = 1'b1; flush_i = 1'b1;
    drive(1'b1, 32'h00500093, 32'h408, 32'h0, 32'h0);
    #1 check("flush.ready", 32'(id_ready_o), 32'd1);
    @(negedge clk);
    check_bubble("flush");
    ex_stall_i = 1'b0; flush_i = 1'b0;

    // Reset while stalled discards the held entry
    drive(1'b1, 32'h00500093, 32'h500, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_stall.pre_valid", 32'(ex_valid_o), 32'd1);
    ex_stall_i = 1'b1; reset = 1'b1;
    @(negedge clk);
    check_bubble("rst_stall");
    check("rst_stall.pc", pc_o, 32'h0);
    reset = 1'b0; ex_stall_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 check("rst_stall.ready", 32'(id_ready_o), 32'd1);
    @(negedge clk);

`ifdef ID_EX_FORWARD_EN
    // Forwarding onto the registered add x3,x1,x2
    drive(1'b1, 32'h002081B3, 32'h600, 32'h0, 32'h22);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    exmem_rd_i = 5'd1; exmem_regwrite_i = 1'b1; exmem_result_i = 32'd7;
    #1 check("fwd.exmem", op1_o, 32'd7);
    memwb_rd_i = 5'd1; memwb_regwrite_i = 1'b1; memwb_result_i = 32'd9;
    #1 check("fwd.both", op1_o, 32'd7);
    exmem_regwrite_i = 1'b0;
    #1 check("fwd.memwb", op1_o, 32'd9);
    memwb_regwrite_i = 1'b0;
    exmem_regwrite_i = 1'b1; exmem_memread_i = 1'b1;
    #1 check("fwd.no_load_fwd", op1_o, 32'd0);
    clear_wb();
    @(negedge clk);

    // Load-use: lw x5 then add x6,x5,x5 costs one bubble
    drive(1'b1, 32'h0000A283, 32'h700, 32'h0, 32'h0);
    #1 check("lu.lw_ready", 32'(id_ready_o), 32'd1);
    @(negedge clk);
    check("lu.lw_valid", 32'(ex_valid_o), 32'd1);
    drive(1'b1, 32'h00528333, 32'h704, 32'h0, 32'h0);
    #1 check("lu.ready_low", 32'(id_ready_o), 32'd0);
    @(negedge clk);
    check_bubble("lu.bubble");
    #1 check("lu.ready_high", 32'(id_ready_o), 32'd1);
    @(negedge clk);
    check("lu.add_valid", 32'(ex_valid_o), 32'd1);
    check("lu.add_instr", instr_o, 32'h00528333);
    exmem_rd_i = 5'd5; exmem_memread_i = 1'b1; exmem_regwrite_i = 1'b1;
    #1 check("lu.exmem_load_hazard", 32'(id_ready_o), 32'd0);
    clear_wb();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
`else
    // add x3,x1,x0 waits for addi x1 to pass EX, EX/MEM and MEM/WB
    drive(1'b1, 32'h00500093, 32'h600, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h000081B3, 32'h604, 32'h0, 32'h0);
    #1 check("raw.ex", 32'(id_ready_o), 32'd0);
    @(negedge clk);
    check("raw.bubble_valid", 32'(ex_valid_o), 32'd0);
    exmem_rd_i = 5'd1; exmem_regwrite_i = 1'b1;
    #1 check("raw.exmem", 32'(id_ready_o), 32'd0);
    @(negedge clk);
    clear_wb();
    memwb_rd_i = 5'd1; memwb_regwrite_i = 1'b1;
    #1 check("raw.memwb", 32'(id_ready_o), 32'd0);
    @(negedge clk);
    clear_wb();
    rs1_data_i = 32'd5;
    #1 check("raw.clear", 32'(id_ready_o), 32'd1);
    @(negedge clk);
    check("raw.issue_valid", 32'(ex_valid_o), 32'd1);
    check("raw.issue_instr", instr_o, 32'h000081B3);
    check("raw.issue_op1", op1_o, 32'd5);

    // x0 as source or destination never stalls
    drive(1'b1, 32'h00100013, 32'h700, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h000001B3, 32'h704, 32'h0, 32'h0);
    exmem_rd_i = 5'd0; exmem_regwrite_i = 1'b1;
    memwb_rd_i = 5'd0; memwb_regwrite_i = 1'b1;
    #1 check("x0.ready", 32'(id_ready_o), 32'd1);
    @(negedge clk);
    check("x0.instr", instr_o, 32'h000001B3);
    clear_wb();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0013, instruction word loaded on reset/bubble/flush.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 if_valid_i  in  1  / if_instr_i  in  32 / if_pc_i  in  32  decoded-stage input.
REQ-005 id_ready_o  out  1  combinational; 1 = input accepted this edge.
REQ-006 rs1_addr_o, rs2_addr_o  out  5 each  combinational from if_instr_i[19:15], [24:20].
REQ-007 rs1_data_i, rs2_data_i  in  32 each  register-file read data for rs1_addr_o/rs2_addr_o.
REQ-008 flush_i  in  1 (taken branch/jump); ex_stall_i  in  1 (downstream hold).
REQ-009 exmem_rd_i 5, exmem_regwrite_i 1, exmem_memread_i 1, exmem_result_i 32; memwb_rd_i 5, memwb_regwrite_i 1, memwb_result_i 32  all in.
REQ-010 ex_valid_o 1, instr_o 32, pc_o 32, sel_o 2, op1_o 32, op2_o 32, store_data_o 32  all out, ALU-facing.

Function
REQ-011 Immediates from if_instr_i: I/L/JALR sign-extended [31:20]; I-shifts zero-extended [24:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}; U = [31:12] right-justified, zero-extended (ALU applies <<12).
REQ-012 sel_o: 00 R-type (rs1,rs2); 01 I/L/S/JALR (rs1,imm); 10 B/JAL (pc,imm); 11 LUI/AUIPC (0,imm); unknown opcodes use 00.
REQ-013 Registered per entry: valid, instr, pc, sel, rs1/rs2 value, rs1/rs2 addr, imm, rd, load flag (opcode 0000011).
REQ-014 Register update priority each edge: reset > flush_i > ex_stall_i (hold all) > hazard bubble > capture of if_* when if_valid_i.
REQ-015 Bubble/flush load: valid=0, instr=NOP_INSTR, sel=01, operands/imm/rd=0.
REQ-016 if_valid_i=0 with no stall/flush: register loads bubble.
REQ-017 id_ready_o = flush_i | (!ex_stall_i & !hazard).
REQ-018 op1_o/op2_o/store_data_o combinational from registered fields after forwarding; pc_o/instr_o/sel_o/ex_valid_o straight from registers.
REQ-019 Address x0 never matches any hazard or forwarding comparison.
REQ-020 Latency: accepted instruction appears on outputs the cycle after acceptance; throughput one per cycle with no hazard.

Reset
REQ-021 On reset edge: ex_valid_o=0, instr_o=NOP_INSTR, pc_o=0, sel_o=01, op1_o=0, op2_o=0, store_data_o=0; reset mid-stall or mid-hazard discards held entry; id_ready_o=1 first cycle after reset absent stall.

Configuration
REQ-022 Macro ID_EX_FORWARD_EN.
REQ-023 Defined: rs value = exmem_result_i if exmem_regwrite_i & !exmem_memread_i & rd match; else memwb_result_i if memwb_regwrite_i & rd match; else registered value (EX/MEM wins when both match). hazard = registered entry valid & load & its rd equals incoming rs1 or rs2 (used fields only): one bubble inserted.
REQ-024 Defined, additionally: exmem_memread_i match with EX/MEM also hazard (no load-result forwarding from EX/MEM).
REQ-025 Undefined: no forwarding; hazard = incoming rs1/rs2 matches rd of valid registered writer, exmem (regwrite), or memwb (regwrite); stall until clear.
REQ-026 Both builds: identical port list and reset values.

Verification
REQ-027 addi x1,x0,5 at pc 0x100 -> next cycle ex_valid_o=1, sel_o=01, op1_o=0, op2_o=5, pc_o=0x100.
REQ-028 FWD_EN: add x3,x1,x2 with exmem_rd_i=1, exmem_result_i=7, rs1_data_i=0 -> op1_o=7; both exmem and memwb rd=1 (7,9) -> op1_o=7.
REQ-029 FWD_EN: lw x5 then add x6,x5,x5 -> id_ready_o=0 one cycle, one bubble (ex_valid_o=0, instr_o=0x13), then add issues.
REQ-030 flush_i with ex_stall_i both 1 -> next cycle ex_valid_o=0, instr_o=NOP_INSTR, id_ready_o=1.
REQ-031 No FWD_EN: add x3,x1,x0 after addi x1 -> id_ready_o=0 until memwb_rd_i=1 retires; x0 dependency never stalls.
REQ-032 lui x2,0x12345 -> sel_o=11, op2_o=0x0001_2345; beq offset -8 at pc 0x200 -> op1_o=0x200, op2_o=0xFFFF_FFF8.
